// File: rtl/giro_pkg.sv
// Shared codes, FSM states and pattern decoding for the rotating-segment reader.
// Pure definitions: no state, no latency, no flow control.
package giro_pkg;

  localparam int N_SIMBOLOS = 6;

  localparam logic [6:0] COD_0      = 7'h42;
  localparam logic [6:0] COD_1      = 7'h44;
  localparam logic [6:0] COD_2      = 7'h48;
  localparam logic [6:0] COD_3      = 7'h50;
  localparam logic [6:0] COD_4      = 7'h60;
  localparam logic [6:0] COD_5      = 7'h41;
  localparam logic [6:0] COD_BRANCO = 7'h40;

  typedef enum logic {BUSCA, SEGUE} estado_t;

  typedef struct packed {
    logic [2:0] indice;
    logic       branco;
    logic       ilegal;
  } simbolo_t;

  function automatic simbolo_t decodifica(input logic [6:0] padrao);
    simbolo_t s;
    s = '{indice: 3'd0, branco: 1'b0, ilegal: 1'b0};
    case (padrao)
      COD_0:      s.indice = 3'd0;
      COD_1:      s.indice = 3'd1;
      COD_2:      s.indice = 3'd2;
      COD_3:      s.indice = 3'd3;
      COD_4:      s.indice = 3'd4;
      COD_5:      s.indice = 3'd5;
      COD_BRANCO: s.branco = 1'b1;
      default:    s.ilegal = 1'b1;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] proximo(input logic [2:0] i);
    return (i == 3'(N_SIMBOLOS - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] anterior(input logic [2:0] i);
    return (i == 3'd0) ? 3'(N_SIMBOLOS - 1) : i - 3'd1;
  endfunction

endpackage

// File: rtl/leitor_giro_filtro.sv
// Accepts a pattern once it has been sampled on ESTAVEL consecutive edges; strobes aceito once.
// Strobe registered on the ESTAVEL-th identical sample; no backpressure, input is free-running.
module filtro_estavel #(
  parameter int ESTAVEL = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] entrada,
  output logic [6:0] estavel,
  output logic       aceito
);

  localparam logic [3:0] ALVO = 4'(ESTAVEL);

  logic [6:0] amostra;
  logic [3:0] cont;
  logic [3:0] cont_prox;
  logic       mudou;
  logic       aceita_prox;

  // cont saturates at ALVO so a pattern held steady is accepted only once
  always_comb begin
    mudou = (entrada != amostra);
    if (mudou)
      cont_prox = 4'd1;
    else if (cont == ALVO)
      cont_prox = cont;
    else
      cont_prox = cont + 4'd1;
    aceita_prox = (cont_prox == ALVO) && (mudou || (cont != ALVO));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      amostra <= 7'd0;
      cont    <= 4'd0;
      estavel <= 7'd0;
      aceito  <= 1'b0;
    end else begin
      amostra <= entrada;
      cont    <= cont_prox;
      aceito  <= aceita_prox;
      if (aceita_prox)
        estavel <= entrada;
    end
  end

endmodule

// File: rtl/leitor_giro.sv
// Decodes the six-step segment rotation: step index, order check, rotation count, stall flag.
// Latency ESTAVEL+1 edges from a steady pattern; no backpressure. LEITOR_GIRO_REVERSO_EN adds reverse steps and direcao.
module leitor_giro
  import giro_pkg::*;
#(
  parameter int ESTAVEL = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] segmentos,
  output logic [2:0] indice,
  output logic       valido,
  output logic       passo,
  output logic       erro_seq,
  output logic [7:0] voltas,
  output logic       parado
`ifdef LEITOR_GIRO_REVERSO_EN
  ,
  output logic       direcao
`endif
);

  localparam logic [15:0] LIMITE = 16'(TIMEOUT);

  logic [6:0]  padrao;
  logic        aceito;
  simbolo_t    sim;
  estado_t     estado;
  logic [15:0] ocioso;
  logic        eh_frente;
  logic        eh_tras;

  filtro_estavel #(.ESTAVEL(ESTAVEL)) u_filtro (
    .clock   (clock),
    .reset   (reset),
    .entrada (segmentos),
    .estavel (padrao),
    .aceito  (aceito)
  );

  assign sim       = decodifica(padrao);
  assign eh_frente = (sim.indice == proximo(indice));
`ifdef LEITOR_GIRO_REVERSO_EN
  assign eh_tras   = (sim.indice == anterior(indice));
`else
  assign eh_tras   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= BUSCA;
      indice   <= 3'd0;
      valido   <= 1'b0;
      passo    <= 1'b0;
      erro_seq <= 1'b0;
      voltas   <= 8'd0;
      parado   <= 1'b0;
      ocioso   <= 16'd0;
`ifdef LEITOR_GIRO_REVERSO_EN
      direcao  <= 1'b0;
`endif
    end else begin
      passo    <= 1'b0;
      erro_seq <= 1'b0;
      // a resync counts as idle time; only real steps or leaving SEGUE restart it
      if (estado == SEGUE && ocioso != LIMITE) begin
        ocioso <= ocioso + 16'd1;
        if (ocioso == LIMITE - 16'd1)
          parado <= 1'b1;
      end
      if (aceito) begin
        if (estado == BUSCA) begin
          if (sim.ilegal) begin
            erro_seq <= 1'b1;
          end else if (!sim.branco) begin
            indice <= sim.indice;
            valido <= 1'b1;
            estado <= SEGUE;
            ocioso <= 16'd0;
            parado <= 1'b0;
          end
        end else if (sim.branco || sim.ilegal) begin
          erro_seq <= sim.ilegal;
          valido   <= 1'b0;
          estado   <= BUSCA;
          ocioso   <= 16'd0;
          parado   <= 1'b0;
        end else if (eh_frente) begin
          passo  <= 1'b1;
          indice <= sim.indice;
          ocioso <= 16'd0;
          parado <= 1'b0;
          if (indice == 3'(N_SIMBOLOS - 1))
            voltas <= voltas + 8'd1;
`ifdef LEITOR_GIRO_REVERSO_EN
          direcao <= 1'b0;
`endif
        end else if (eh_tras) begin
          passo  <= 1'b1;
          indice <= sim.indice;
          ocioso <= 16'd0;
          parado <= 1'b0;
          if (indice == 3'd0)
            voltas <= voltas + 8'd1;
`ifdef LEITOR_GIRO_REVERSO_EN
          direcao <= 1'b1;
`endif
        end else begin
          erro_seq <= 1'b1;
          indice   <= sim.indice;
        end
      end
    end
  end

endmodule

// File: tb/tb_leitor_giro.sv
// Bench for leitor_giro: cycle-by-cycle comparison against a run-length/rule model plus directed literal checks.
module tb_leitor_giro;

  localparam int ESTAVEL = 3;
  localparam int TIMEOUT = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] segmentos;
  logic [2:0] indice;
  logic       valido, passo, erro_seq, parado;
  logic [7:0] voltas;
`ifdef LEITOR_GIRO_REVERSO_EN
  logic       direcao;
`endif

  leitor_giro #(.ESTAVEL(ESTAVEL), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .segmentos (segmentos),
    .indice    (indice),
    .valido    (valido),
    .passo     (passo),
    .erro_seq  (erro_seq),
    .voltas    (voltas),
    .parado    (parado)
`ifdef LEITOR_GIRO_REVERSO_EN
    ,
    .direcao   (direcao)
`endif
  );

  always #5 clock = ~clock;

  int testes = 0;
  int falhas = 0;

  task automatic cmp(input string nome, input int atual, input int esperado);
    testes++;
    if (atual != esperado) begin
      falhas++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   codigos [6] = '{'h42, 'h44, 'h48, 'h50, 'h60, 'h41};
  logic [6:0] m_ultimo;
  int   m_corrida;
  bit   m_pend;
  logic [6:0] m_pval;
  bit   m_travado, m_passo, m_erro, m_dir;
  int   m_idx, m_voltas, m_ciclos;
  bit   modelo_ok = 0;

  function automatic int procura(input logic [6:0] v);
    for (int i = 0; i < 6; i++)
      if (int'(v) == codigos[i]) return i;
    return (v == 7'h40) ? -1 : -2;
  endfunction

  task automatic aplica(input logic [6:0] v);
    int c;
    c = procura(v);
    if (!m_travado) begin
      if (c >= 0) begin
        m_idx = c; m_travado = 1; m_ciclos = 0;
      end else if (c == -2) m_erro = 1;
    end else if (c == -1) begin
      m_travado = 0;
    end else if (c == -2) begin
      m_erro = 1; m_travado = 0;
    end else if (c == (m_idx + 1) % 6) begin
      m_passo = 1; m_dir = 0; m_ciclos = 0;
      if (m_idx == 5) m_voltas = (m_voltas + 1) % 256;
      m_idx = c;
`ifdef LEITOR_GIRO_REVERSO_EN
    end else if (c == (m_idx + 5) % 6) begin
      m_passo = 1; m_dir = 1; m_ciclos = 0;
      if (m_idx == 0) m_voltas = (m_voltas + 1) % 256;
      m_idx = c;
`endif
    end else begin
      m_erro = 1; m_idx = c;
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_ultimo = 7'd0; m_corrida = 0; m_pend = 0; m_pval = 7'd0;
      m_travado = 0; m_passo = 0; m_erro = 0; m_dir = 0;
      m_idx = 0; m_voltas = 0; m_ciclos = 0;
      modelo_ok = 1;
    end else begin
      m_passo = 0; m_erro = 0;
      if (m_travado) m_ciclos++;
      if (m_pend) aplica(m_pval);
      // a pattern is accepted when its run of identical samples first reaches ESTAVEL
      if (segmentos == m_ultimo) m_corrida++;
      else m_corrida = 1;
      m_ultimo = segmentos;
      m_pend = (m_corrida == ESTAVEL);
      m_pval = segmentos;
    end
  end

  always @(negedge clock) begin
    if (modelo_ok) begin
      cmp("valido", int'(valido), int'(m_travado));
      if (m_travado) cmp("indice", int'(indice), m_idx);
      cmp("passo", int'(passo), int'(m_passo));
      cmp("erro_seq", int'(erro_seq), int'(m_erro));
      cmp("voltas", int'(voltas), m_voltas);
      cmp("parado", int'(parado), int'(m_travado && m_ciclos >= TIMEOUT));
`ifdef LEITOR_GIRO_REVERSO_EN
      cmp("direcao", int'(direcao), int'(m_dir));
`endif
    end
  end

  int n_passo = 0;
  int n_erro = 0;
  always @(negedge clock) begin
    if (passo) n_passo++;
    if (erro_seq) n_erro++;
  end

  // ---------------- directed stimulus ----------------
  task automatic hold(input logic [6:0] v, input int n);
    segmentos = v;
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, e0;
    reset = 1'b1;
    segmentos = 7'h40;
    repeat (3) @(negedge clock);
    #1;
    cmp("rst_indice", int'(indice), 0);
    cmp("rst_valido", int'(valido), 0);
    cmp("rst_passo", int'(passo), 0);
    cmp("rst_erro", int'(erro_seq), 0);
    cmp("rst_voltas", int'(voltas), 0);
    cmp("rst_parado", int'(parado), 0);
`ifdef LEITOR_GIRO_REVERSO_EN
    cmp("rst_direcao", int'(direcao), 0);
`endif
    reset = 1'b0;

    // one full rotation plus return to step 0
    hold(7'h40, 5);
    hold(7'h42, 5);
    cmp("rot_lock_valido", int'(valido), 1);
    hold(7'h44, 5); hold(7'h48, 5); hold(7'h50, 5);
    hold(7'h60, 5); hold(7'h41, 5); hold(7'h42, 5);
    cmp("rot_passos", n_passo, 6);
    cmp("rot_erros", n_erro, 0);
    cmp("rot_voltas", int'(voltas), 1);
    cmp("rot_indice", int'(indice), 0);

    // short glitch is never accepted; latency of ESTAVEL+1 edges
    hold(7'h40, 5);
    cmp("blank_valido", int'(valido), 0);
    hold(7'h42, 2);
    hold(7'h44, 3);
    cmp("lat_early_valido", int'(valido), 0);
    hold(7'h44, 1);
    cmp("lat_valido", int'(valido), 1);
    cmp("lat_indice", int'(indice), 1);
    hold(7'h44, 1);

    // out-of-order step resyncs
    p0 = n_passo; e0 = n_erro;
    hold(7'h60, 5);
    cmp("oos_erros", n_erro - e0, 1);
    cmp("oos_passos", n_passo - p0, 0);
    cmp("oos_indice", int'(indice), 4);
    cmp("oos_voltas", int'(voltas), 1);

    // blank drops lock without error
    e0 = n_erro;
    hold(7'h40, 5);
    cmp("blk_valido", int'(valido), 0);
    cmp("blk_erros", n_erro - e0, 0);

    // illegal pattern while locked
    hold(7'h42, 5);
    e0 = n_erro;
    hold(7'h7F, 5);
    cmp("ileg_erros", n_erro - e0, 1);
    cmp("ileg_valido", int'(valido), 0);

    // stall detection at exactly TIMEOUT cycles after lock
    hold(7'h48, 23);
    cmp("stall_pre", int'(parado), 0);
    hold(7'h48, 1);
    cmp("stall_set", int'(parado), 1);
    hold(7'h50, 3);
    cmp("stall_hold", int'(parado), 1);
    hold(7'h50, 1);
    cmp("stall_passo", int'(passo), 1);
    cmp("stall_clr", int'(parado), 0);
    hold(7'h50, 19);
    cmp("stall2_pre", int'(parado), 0);
    hold(7'h50, 1);
    cmp("stall2_set", int'(parado), 1);
    hold(7'h42, 4);
    cmp("resync_erro", int'(erro_seq), 1);
    cmp("resync_parado", int'(parado), 1);
    cmp("resync_indice", int'(indice), 0);
    hold(7'h42, 1);

    // reverse step 0 -> 5
    hold(7'h41, 4);
`ifdef LEITOR_GIRO_REVERSO_EN
    cmp("rev_passo", int'(passo), 1);
    cmp("rev_direcao", int'(direcao), 1);
    cmp("rev_voltas", int'(voltas), 2);
`else
    cmp("rev_erro", int'(erro_seq), 1);
    cmp("rev_passo", int'(passo), 0);
    cmp("rev_voltas", int'(voltas), 1);
`endif
    cmp("rev_indice", int'(indice), 5);
    hold(7'h41, 1);

    // reset mid-operation discards partial filter count
    hold(7'h44, 2);
    reset = 1'b1;
    hold(7'h44, 1);
    cmp("mid_rst_valido", int'(valido), 0);
    cmp("mid_rst_voltas", int'(voltas), 0);
    reset = 1'b0;
    hold(7'h44, 3);
    cmp("mid_early_valido", int'(valido), 0);
    hold(7'h44, 1);
    cmp("mid_valido", int'(valido), 1);
    cmp("mid_indice", int'(indice), 1);
    hold(7'h44, 2);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
